// File: rtl/frame_fetcher.sv
// frame_fetcher
// Write-side producer for the pixel FIFO drained by the VGA timing generator.
// Reads a linear frame memory in raster order (0 .. H_ACTIVE*V_ACTIVE-1,
// wrapping at end of frame) and pushes each returned word into the FIFO a
// fixed MEM_LATENCY+1 cycles after its read was issued. Reads are throttled
// by credit (FIFO fill + reads in flight), so the FIFO can never overflow.
//
// Ports:
//   clk           write-side clock
//   rst           synchronous active-high reset
//   enable        run request, sampled in IDLE and at the last read of a frame
//   mem_rd        memory read strobe, one word per asserted cycle
//   mem_addr      read address, valid while mem_rd=1
//   mem_rdata     read data {R,G,B}, valid MEM_LATENCY cycles after mem_rd
//   fifo_wrusedw  FIFO write-side fill count (may lag by one cycle)
//   fifo_wreq     FIFO write strobe
//   fifo_data     FIFO write data
//   frame_done    one-cycle pulse with the write of the last pixel of a frame
//   busy          high while fetching or draining
module frame_fetcher #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned USEDW_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [23:0]        mem_rdata,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  output logic               fifo_wreq,
  output logic [23:0]        fifo_data,
  output logic               frame_done,
  output logic               busy
);

  localparam int unsigned INF_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = USEDW_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [SUM_W-1:0]  CREDIT_MAX = SUM_W'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [INF_W-1:0]       inflight_q, inflight_d;
  logic [MEM_LATENCY-1:0] vld_q;
  logic [MEM_LATENCY:0]   vld_chain;
  logic [ADDR_W-1:0]      wpix_q;
  logic                   fifo_wreq_q;
  logic                   frame_done_q;
  logic [23:0]            fifo_data_q;
  logic                   credit_ok;
  logic                   rd_arrive;

  // One word of slack below full absorbs the one-cycle lag of fifo_wrusedw.
  // The sum is formed one bit wider than the fill count so it cannot wrap.
  assign credit_ok = ({1'b0, fifo_wrusedw} + SUM_W'(inflight_q)) <= CREDIT_MAX;

  // Valid tag travelling alongside each read; its tail marks the cycle in
  // which mem_rdata belongs to an issued read.
  assign vld_chain = {vld_q, mem_rd};
  assign rd_arrive = vld_q[MEM_LATENCY-1];

  // Reads issued but not yet written into the FIFO.
  always_comb begin
    inflight_d = inflight_q;
    case ({mem_rd, fifo_wreq_q})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        if (mem_rd) begin
          if (addr_q == LAST_PIX) begin
            // Frame boundary: the only point where a dropped enable is honoured.
            addr_d = '0;
            if (!enable) state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final outstanding write is on the FIFO port,
        // so busy drops the cycle after the last fifo_wreq.
        if (inflight_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    mem_rd = 1'b0;
    busy   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = credit_ok;
        busy   = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      default: begin
        mem_rd = 1'b0;
        busy   = 1'b0;
      end
    endcase
  end

  assign mem_addr = addr_q;

  // Return path: register the arriving word into the FIFO write port and
  // count written pixels to flag the end of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      fifo_wreq_q  <= 1'b0;
      fifo_data_q  <= '0;
      frame_done_q <= 1'b0;
      wpix_q       <= '0;
    end else begin
      vld_q        <= vld_chain[MEM_LATENCY-1:0];
      fifo_wreq_q  <= rd_arrive;
      frame_done_q <= rd_arrive && (wpix_q == LAST_PIX);
      if (rd_arrive) begin
        fifo_data_q <= mem_rdata;
        wpix_q      <= (wpix_q == LAST_PIX) ? '0 : wpix_q + ADDR_W'(1);
      end
    end
  end

  assign fifo_wreq  = fifo_wreq_q;
  assign fifo_data  = fifo_data_q;
  assign frame_done = frame_done_q;

endmodule
